// File: rtl/toggle_arb_pkg.sv
// toggle_arb_pkg: shared types, widths and legal parameter ranges for toggle_arbiter
package toggle_arb_pkg;
    typedef enum logic {IDLE, GRANT} state_t;
    localparam int N_REQ_MIN = 2;
    localparam int N_REQ_MAX = 16;
    localparam int MAX_HOLD_MIN = 1;
    localparam int MAX_HOLD_MAX = 255;
    localparam int HOLD_W = 8;
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/toggle_arbiter_rr_pick.sv
// rr_pick: combinational round-robin one-hot picker, first eligible index at or after ptr
module rr_pick
    import toggle_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        elig,
    input  logic [ptr_w(N)-1:0] ptr,
    output logic [N-1:0]        win,
    output logic                valid
);
    logic [N-1:0] r;
    logic [N-1:0] w;
    // rotate so ptr lands at bit 0, take the lowest set bit, rotate back
    assign r     = N'({elig, elig} >> ptr);
    assign w     = r & (~r + N'(1));
    assign win   = N'(({w, w} << ptr) >> N);
    assign valid = |elig;
endmodule

// File: rtl/toggle_arbiter.sv
// toggle_arbiter: round-robin sharing of one toggle state machine (A <= A ^ X ^ Y) among N_REQ requesters.
// Define TOGGLE_ARB_LOCK_EN to let a granted requester hold the grant for up to MAX_HOLD cycles.
module toggle_arbiter
    import toggle_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] x_in,
    input  logic [N_REQ-1:0] y_in,
    input  logic [N_REQ-1:0] lock,
    output logic [N_REQ-1:0] gnt,
    output logic             sm_x,
    output logic             sm_y,
    input  logic             sm_a,
    output logic [N_REQ-1:0] done,
    output logic             a_out
);
    localparam int PW = ptr_w(N_REQ);

    if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX ||
        MAX_HOLD < MAX_HOLD_MIN || MAX_HOLD > MAX_HOLD_MAX) begin : g_bad_param
        $error("toggle_arbiter: parameter out of range");
    end

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_next;
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  win;
    logic              valid;
    logic              ext;

`ifdef TOGGLE_ARB_LOCK_EN
    logic [HOLD_W-1:0] hold;
    assign ext = (state == GRANT) && |(gnt & lock & req) && (hold < HOLD_W'(MAX_HOLD - 1));
`else
    logic unused_lock;
    assign unused_lock = ^lock;
    assign ext = 1'b0;
`endif

    // the requester granted this cycle sits out the next pick
    assign elig = (state == GRANT) ? (req & ~gnt) : req;

    rr_pick #(.N(N_REQ)) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .win   (win),
        .valid (valid)
    );

    always_comb begin
        ptr_next = ptr;
        for (int i = 0; i < N_REQ; i++)
            if (win[i]) ptr_next = (i == N_REQ - 1) ? '0 : PW'(i + 1);
    end

    assign sm_x = |(gnt & x_in);
    assign sm_y = |(gnt & y_in);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            a_out <= 1'b0;
            ptr   <= '0;
`ifdef TOGGLE_ARB_LOCK_EN
            hold  <= '0;
`endif
        end else begin
            done  <= gnt;
            // capture the value the state machine takes at this same edge
            a_out <= sm_a ^ sm_x ^ sm_y;
            if (ext) begin
                state <= GRANT;
`ifdef TOGGLE_ARB_LOCK_EN
                hold  <= hold + 1'b1;
`endif
            end else begin
                state <= valid ? GRANT : IDLE;
                gnt   <= win;
                if (valid) ptr <= ptr_next;
`ifdef TOGGLE_ARB_LOCK_EN
                hold  <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_toggle_arbiter.sv
// tb_toggle_arbiter: scoreboarded random and directed test of toggle_arbiter with a shared toggle state machine
module tb_toggle_arbiter;
    localparam int N = 4;
    localparam int MAX_HOLD = 8;

    typedef struct {
        int idx;
        bit a;
    } done_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [N-1:0] req = '0, x_in = '0, y_in = '0, lock = '0;
    logic [N-1:0] gnt, done;
    logic         sm_x, sm_y, sm_a, a_out;

    toggle_arbiter #(.N_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
        .CLK(CLK), .RST(RST), .req(req), .x_in(x_in), .y_in(y_in), .lock(lock),
        .gnt(gnt), .sm_x(sm_x), .sm_y(sm_y), .sm_a(sm_a), .done(done), .a_out(a_out)
    );

    // shared toggle state machine beside the arbiter
    always_ff @(posedge CLK or negedge RST)
        if (!RST) sm_a <= 1'b0;
        else sm_a <= sm_a ^ sm_x ^ sm_y;

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_fail = 0;
    bit run = 0;
    logic [N-1:0] gnt_q[$];
    done_t        done_q[$];
    int m_ptr = 0, m_cur = -1, m_hold = 0;
    bit m_a = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: grant bookkeeping from the round-robin / lock rules at one clock edge
    task automatic model();
        int nxt;
        if (m_cur >= 0) begin
            m_a = m_a ^ x_in[m_cur] ^ y_in[m_cur];
            done_q.push_back('{m_cur, m_a});
        end
        nxt = -1;
`ifdef TOGGLE_ARB_LOCK_EN
        if (m_cur >= 0 && lock[m_cur] && req[m_cur] && m_hold < MAX_HOLD - 1) begin
            nxt = m_cur;
            m_hold++;
        end
`endif
        if (nxt < 0) begin
            m_hold = 0;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (nxt < 0 && req[i] && i != m_cur) nxt = i;
            end
            if (nxt >= 0) m_ptr = (nxt + 1) % N;
        end
        m_cur = nxt;
        gnt_q.push_back(nxt < 0 ? '0 : N'(1) << nxt);
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] xv,
                        input logic [N-1:0] yv, input logic [N-1:0] lv);
        @(posedge CLK);
        #1;
        model();
        run  = 1;
        req  = r;
        x_in = xv;
        y_in = yv;
        lock = lv;
    endtask

    task automatic do_reset();
        #2;
        run = 0;
        RST = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sm_x", 32'(sm_x), 0);
        chk("rst_sm_y", 32'(sm_y), 0);
        chk("rst_a", 32'(sm_a), 0);
        chk("rst_a_out", 32'(a_out), 0);
        gnt_q.delete();
        done_q.delete();
        req = '0; x_in = '0; y_in = '0; lock = '0;
        @(negedge CLK);
        RST = 1'b1;
        m_ptr = 0; m_cur = -1; m_hold = 0; m_a = 0;
    endtask

    always @(negedge CLK) begin
        logic [N-1:0] eg;
        done_t d;
        if (run) begin
            if (gnt_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL gnt_q: no expected grant queued at %0t", $time);
                eg = '0;
            end else eg = gnt_q.pop_front();
            chk("gnt", 32'(gnt), 32'(eg));
            chk("sm_x", 32'(sm_x), 32'(|(eg & x_in)));
            chk("sm_y", 32'(sm_y), 32'(|(eg & y_in)));
            chk("sm_a", 32'(sm_a), 32'(m_a));
            if (done != '0) begin
                if (done_q.size() == 0) chk("done_unexpected", 32'(done), 0);
                else begin
                    d = done_q.pop_front();
                    chk("done", 32'(done), 32'(N'(1) << d.idx));
                    chk("a_out", 32'(a_out), 32'(d.a));
                end
            end
            if (done_q.size() != 0) begin
                chk("done_missing", 32'(done), 32'(N'(1) << done_q[0].idx));
                done_q.delete();
            end
        end
    end

    initial begin
        do_reset();
        // single request: X=1, Y=0 toggles A to 1
        step(4'b0010, 4'b0010, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // reset in the middle of a grant cycle
        step(4'b0010, 4'b0010, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        do_reset();
        // full load from reset
        repeat (7) step(4'b1111, N'($urandom), N'($urandom), 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // wrap priority with ptr at 2
        do_reset();
        step(4'b0010, 4'b0000, 4'b0000, 4'b0000);
        repeat (3) step(4'b1010, 4'b1000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // no-toggle grant with A = 1
        if (!m_a) step(4'b0001, 4'b0001, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0001, 4'b0001, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // lock extension attempt on requester 2 with ptr at 2
        do_reset();
        step(4'b0010, 4'b0000, 4'b0000, 4'b0000);
        repeat (12) step(4'b0101, N'($urandom), N'($urandom), 4'b0100);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // random traffic
        for (int t = 0; t < 400; t++)
            step(N'($urandom), N'($urandom), N'($urandom),
                 ($urandom_range(0, 3) != 0) ? N'($urandom) : N'(0));
        repeat (3) step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        @(negedge CLK);
        #1;
        run = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
